// File: rtl/arm_pipe_pkg.sv
// Shared types and constants for the pipeline hazard controller: in-flight entry
// record, default register address width and forwarding-select encoding.
package arm_pipe_pkg;

    localparam int DEF_REG_ADDR_W = 4;
    // Entries store destinations zero-extended to this width so the record type
    // does not depend on the instantiating module's address width.
    localparam int ENTRY_ADDR_W   = 8;

    // Forwarding select 0 means "read the register file"; k+1 means entry k.
    localparam int FWD_RF         = 0;

    typedef struct packed {
        logic                    valid;
        logic [ENTRY_ADDR_W-1:0] dest;
        logic                    wb_en;
        logic                    mem_r_en;
    } pipe_entry_t;

    localparam pipe_entry_t BUBBLE = '{
        valid:    1'b0,
        dest:     {ENTRY_ADDR_W{1'b0}},
        wb_en:    1'b0,
        mem_r_en: 1'b0
    };

    function automatic pipe_entry_t make_entry(
        input logic                    valid,
        input logic [ENTRY_ADDR_W-1:0] dest,
        input logic                    wb_en,
        input logic                    mem_r_en
    );
        pipe_entry_t e;
        e.valid    = valid;
        e.dest     = dest;
        e.wb_en    = wb_en;
        e.mem_r_en = mem_r_en;
        return e;
    endfunction

endpackage

// File: rtl/pipe_src_match.sv
// Per-source dependency check against the in-flight entries: match vector,
// youngest-producer forwarding select and hazard bit (see PIPE_HAZARD_FWD_EN).
module pipe_src_match
    import arm_pipe_pkg::*;
#(
    parameter int REG_ADDR_W = DEF_REG_ADDR_W,
    parameter int DEPTH      = 3,
    parameter int SEL_W      = $clog2(DEPTH + 1)
) (
    input  logic                  id_valid,
    input  logic                  src_used,
    input  logic [REG_ADDR_W-1:0] src,
    input  pipe_entry_t [DEPTH-1:0] entries,
    output logic [SEL_W-1:0]      sel,
    output logic                  hazard
);

    logic [ENTRY_ADDR_W-1:0] src_ext_s;
    logic [DEPTH-1:0]        match_s;
    logic [SEL_W-1:0]        sel_s;
    logic                    hazard_s;
    logic                    unused_entry_bits_s;

    assign src_ext_s = ENTRY_ADDR_W'(src);
    assign unused_entry_bits_s = ^entries;

    // Which in-flight entries produce the register this source reads
    always_comb begin
        match_s = {DEPTH{1'b0}};
        for (int k = 0; k < DEPTH; k++) begin
            match_s[k] = id_valid & src_used & entries[k].valid & entries[k].wb_en
                       & (entries[k].dest == src_ext_s);
        end
    end

`ifdef PIPE_HAZARD_FWD_EN
    // Youngest producer wins; only a load still in EXE cannot be forwarded
    always_comb begin
        sel_s = SEL_W'(FWD_RF);
        for (int k = DEPTH - 1; k >= 0; k--) begin
            sel_s = match_s[k] ? SEL_W'(k + 1) : sel_s;
        end
        hazard_s = match_s[0] & entries[0].mem_r_en;
    end
`else
    // Without bypass paths any producer short of WB forces a stall
    always_comb begin
        sel_s    = SEL_W'(FWD_RF);
        hazard_s = |match_s[DEPTH-2:0];
    end
`endif

    assign sel    = sel_s;
    assign hazard = hazard_s;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: tracks in-flight instructions after ID and
// produces stall/flush/forwarding selects. Bypass enabled by PIPE_HAZARD_FWD_EN.
module pipe_hazard_ctrl
    import arm_pipe_pkg::*;
#(
    parameter int REG_ADDR_W = DEF_REG_ADDR_W,
    parameter int DEPTH      = 3,
    parameter int NUM_SRC    = 2,
    parameter int SEL_W      = $clog2(DEPTH + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          id_valid,
    input  logic [REG_ADDR_W-1:0]         id_dest,
    input  logic                          id_wb_en,
    input  logic                          id_mem_r_en,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] id_src,
    input  logic [NUM_SRC-1:0]            id_src_used,
    input  logic                          branch_taken,
    input  logic                          mem_ready,
    output logic                          stall,
    output logic                          flush,
    output logic [NUM_SRC*SEL_W-1:0]      fwd_sel,
    output logic [31:0]                   stall_count
);

    pipe_entry_t [DEPTH-1:0] entries_r;
    pipe_entry_t             id_entry_s;
    logic [NUM_SRC-1:0]      hazard_s;
    logic                    raw_hazard_s;
    logic                    flush_s;
    logic                    stall_s;
    logic                    accept_s;
    logic [31:0]             stall_count_r;

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        pipe_src_match #(
            .REG_ADDR_W (REG_ADDR_W),
            .DEPTH      (DEPTH),
            .SEL_W      (SEL_W)
        ) u_match (
            .id_valid (id_valid),
            .src_used (id_src_used[s]),
            .src      (id_src[s*REG_ADDR_W +: REG_ADDR_W]),
            .entries  (entries_r),
            .sel      (fwd_sel[s*SEL_W +: SEL_W]),
            .hazard   (hazard_s[s])
        );
    end

    assign raw_hazard_s = |hazard_s;
    assign id_entry_s   = make_entry(1'b1, ENTRY_ADDR_W'(id_dest), id_wb_en, id_mem_r_en);

    // A taken branch squashes ID, so any RAW hazard on that instruction is moot
    always_comb begin
        flush_s  = branch_taken & mem_ready;
        stall_s  = ~mem_ready | (raw_hazard_s & ~flush_s);
        accept_s = id_valid & ~raw_hazard_s & ~flush_s;
    end

    // In-flight entry shift register; holds while memory is not ready
    always_ff @(posedge clk) begin
        if (rst) begin
            entries_r <= {DEPTH{BUBBLE}};
        end else if (mem_ready) begin
            for (int k = DEPTH - 1; k >= 1; k--) begin
                entries_r[k] <= entries_r[k-1];
            end
            entries_r[0] <= accept_s ? id_entry_s : BUBBLE;
        end else begin
            entries_r <= entries_r;
        end
    end

    // Saturating count of stalled cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count_r <= 32'd0;
        end else if (stall_s && (stall_count_r != 32'hFFFF_FFFF)) begin
            stall_count_r <= stall_count_r + 32'd1;
        end else begin
            stall_count_r <= stall_count_r;
        end
    end

    assign stall       = stall_s;
    assign flush       = flush_s;
    assign stall_count = stall_count_r;

endmodule
